srai_accel_axil_ctrl_slave: RTL

AXI-Lite responder (slave end of the accelerator AXI-Lite control interface) terminating host register accesses for one HLS kernel. Holds the ap_ctrl handshake (start/done/idle/ready), interrupt enable/status, and NUM_ARGS 32-bit scalar argument registers driven to the kernel. Sits between the host-side AXI-Lite interconnect and the kernel's ap_ctrl/scalar ports.

---
 rtl/srai_accel_axil_ctrl_slave_if.sv | 60 ++++++
 rtl/srai_accel_axil_ctrl_slave.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/srai_accel_axil_ctrl_slave_if.sv
// ---------------------------------------------------------------------------
// srai_accel_axil_ctrl_slave_if
//   AXI-Lite control-bus bundle between the host interconnect (master) and
//   the accelerator control-register block (slave).
//
//   Parameters : AW - address width, DW - data width (32 only)
//   Channels   : AW (awaddr/awprot/awvalid/awready)
//                W  (wdata/wstrb/wvalid/wready)
//                B  (bresp/bvalid/bready)
//                AR (araddr/arprot/arvalid/arready)
//                R  (rdata/rresp/rvalid/rready)
// ---------------------------------------------------------------------------
interface srai_accel_axil_ctrl_slave_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic [AW-1:0]   AXI_LITE_awaddr;
    logic [2:0]      AXI_LITE_awprot;
    logic            AXI_LITE_awvalid;
    logic            AXI_LITE_awready;
    logic [DW-1:0]   AXI_LITE_wdata;
    logic [DW/8-1:0] AXI_LITE_wstrb;
    logic            AXI_LITE_wvalid;
    logic            AXI_LITE_wready;
    logic [1:0]      AXI_LITE_bresp;
    logic            AXI_LITE_bvalid;
    logic            AXI_LITE_bready;
    logic [AW-1:0]   AXI_LITE_araddr;
    logic [2:0]      AXI_LITE_arprot;
    logic            AXI_LITE_arvalid;
    logic            AXI_LITE_arready;
    logic [DW-1:0]   AXI_LITE_rdata;
    logic [1:0]      AXI_LITE_rresp;
    logic            AXI_LITE_rvalid;
    logic            AXI_LITE_rready;

    modport master (
        output AXI_LITE_awaddr, AXI_LITE_awprot, AXI_LITE_awvalid,
        output AXI_LITE_wdata, AXI_LITE_wstrb, AXI_LITE_wvalid,
        output AXI_LITE_bready,
        output AXI_LITE_araddr, AXI_LITE_arprot, AXI_LITE_arvalid,
        output AXI_LITE_rready,
        input  AXI_LITE_awready, AXI_LITE_wready,
        input  AXI_LITE_bresp, AXI_LITE_bvalid,
        input  AXI_LITE_arready,
        input  AXI_LITE_rdata, AXI_LITE_rresp, AXI_LITE_rvalid
    );

    modport slave (
        input  AXI_LITE_awaddr, AXI_LITE_awprot, AXI_LITE_awvalid,
        input  AXI_LITE_wdata, AXI_LITE_wstrb, AXI_LITE_wvalid,
        input  AXI_LITE_bready,
        input  AXI_LITE_araddr, AXI_LITE_arprot, AXI_LITE_arvalid,
        input  AXI_LITE_rready,
        output AXI_LITE_awready, AXI_LITE_wready,
        output AXI_LITE_bresp, AXI_LITE_bvalid,
        output AXI_LITE_arready,
        output AXI_LITE_rdata, AXI_LITE_rresp, AXI_LITE_rvalid
    );
endinterface

// File: rtl/srai_accel_axil_ctrl_slave.sv
// ---------------------------------------------------------------------------
// srai_accel_axil_ctrl_slave
//   AXI-Lite responder holding the control registers of one HLS kernel:
//   ap_ctrl handshake, interrupt enable/status and NUM_ARGS scalar arguments.
//
//   Ports:
//     clk, rst_n  - clock, asynchronous active-low reset
//     axil        - AXI-Lite slave modport (all five channels)
//     ap_start    - kernel start (out)
//     ap_done     - kernel done pulse (in)
//     ap_idle     - kernel idle level (in)
//     ap_ready    - kernel consumed start (in)
//     args        - ARGi at bits [DW*i +: DW] (out)
//     irq         - registered interrupt level GIE & IER & ISR (out)
//
//   Register map (word index = addr[AW-1:2]):
//     0 CTRL  b0 ap_start, b1 done_sticky (clear-on-read), b2 ap_idle, b3 ap_ready
//     1 GIE   b0
//     2 IER   b0
//     3 ISR   b0, write-1-to-clear
//     4+i ARGi
// ---------------------------------------------------------------------------
module srai_accel_axil_ctrl_slave #(
    parameter int AW       = 12,
    parameter int DW       = 32,
    parameter int NUM_ARGS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    srai_accel_axil_ctrl_slave_if.slave axil,
    output logic                       ap_start,
    input  logic                       ap_done,
    input  logic                       ap_idle,
    input  logic                       ap_ready,
    output logic [NUM_ARGS*DW-1:0]     args,
    output logic                       irq
);

    localparam int IW = AW - 2;
    localparam int SW = DW / 8;

    localparam logic [IW-1:0] IDX_CTRL = IW'(0);
    localparam logic [IW-1:0] IDX_GIE  = IW'(1);
    localparam logic [IW-1:0] IDX_IER  = IW'(2);
    localparam logic [IW-1:0] IDX_ISR  = IW'(3);
    localparam logic [IW-1:0] IDX_ARG0 = IW'(4);

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    // ---------------- write channel FSM ----------------
    w_state_e w_state_q;
    logic     wacc_q;       // one-cycle awready/wready pulse
    logic     bvalid_q;
    logic     wr_hs;
    logic [IW-1:0] wr_idx;

    assign wr_idx = axil.AXI_LITE_awaddr[AW-1:2];
    assign wr_hs  = wacc_q & axil.AXI_LITE_awvalid & axil.AXI_LITE_wvalid;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            wacc_q    <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (wacc_q) begin
                        // Accept pulse is exactly one cycle; a master that
                        // dropped its valids simply gets re-evaluated.
                        wacc_q <= 1'b0;
                        if (wr_hs) begin
                            bvalid_q  <= 1'b1;
                            w_state_q <= W_RESP;
                        end
                    end else if (axil.AXI_LITE_awvalid && axil.AXI_LITE_wvalid) begin
                        wacc_q <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (axil.AXI_LITE_bready) begin
                        bvalid_q  <= 1'b0;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    assign axil.AXI_LITE_awready = wacc_q;
    assign axil.AXI_LITE_wready  = wacc_q;
    assign axil.AXI_LITE_bvalid  = bvalid_q;
    assign axil.AXI_LITE_bresp   = 2'b00;

    // ---------------- register file ----------------
    logic          ap_start_q, ap_start_d;
    logic          done_q, done_d;
    logic          gie_q, gie_d;
    logic          ier_q, ier_d;
    logic          isr_q, isr_d;
    logic          irq_q;
    logic [DW-1:0] arg_q [NUM_ARGS];
    logic [DW-1:0] arg_d [NUM_ARGS];

    logic          ar_hs;
    logic [IW-1:0] rd_idx;
    logic [DW-1:0] rd_mux;
    logic          wr_bit0;

    assign rd_idx  = axil.AXI_LITE_araddr[AW-1:2];
    assign wr_bit0 = wr_hs & axil.AXI_LITE_wstrb[0] & axil.AXI_LITE_wdata[0];

    // NOTE: every always_comb output gets a default before any condition so
    // no path leaves it unassigned (which would infer a latch).
    always_comb begin
        ap_start_d = ap_start_q;
        done_d     = done_q;
        gie_d      = gie_q;
        ier_d      = ier_q;
        isr_d      = isr_q;

        // Later assignments win: a host set beats ap_ready, ap_done beats clears.
        if (ap_ready) ap_start_d = 1'b0;
        if (wr_bit0 && wr_idx == IDX_CTRL) ap_start_d = 1'b1;

        if (ar_hs && rd_idx == IDX_CTRL) done_d = 1'b0;
        if (ap_done) done_d = 1'b1;

        if (wr_hs && wr_idx == IDX_GIE && axil.AXI_LITE_wstrb[0]) gie_d = axil.AXI_LITE_wdata[0];
        if (wr_hs && wr_idx == IDX_IER && axil.AXI_LITE_wstrb[0]) ier_d = axil.AXI_LITE_wdata[0];

        if (wr_bit0 && wr_idx == IDX_ISR) isr_d = 1'b0;
        if (ap_done) isr_d = 1'b1;

        for (int i = 0; i < NUM_ARGS; i++) begin
            arg_d[i] = arg_q[i];
            if (wr_hs && wr_idx == IDX_ARG0 + IW'(i)) begin
                for (int b = 0; b < SW; b++) begin
                    if (axil.AXI_LITE_wstrb[b]) arg_d[i][8*b +: 8] = axil.AXI_LITE_wdata[8*b +: 8];
                end
            end
        end
    end

    // NOTE: the argument array is a handful of flops driving kernel ports, not
    // a RAM, so it is reset like any other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ap_start_q <= 1'b0;
            done_q     <= 1'b0;
            gie_q      <= 1'b0;
            ier_q      <= 1'b0;
            isr_q      <= 1'b0;
            irq_q      <= 1'b0;
            for (int i = 0; i < NUM_ARGS; i++) arg_q[i] <= '0;
        end else begin
            ap_start_q <= ap_start_d;
            done_q     <= done_d;
            gie_q      <= gie_d;
            ier_q      <= ier_d;
            isr_q      <= isr_d;
            irq_q      <= gie_q & ier_q & isr_q;
            for (int i = 0; i < NUM_ARGS; i++) arg_q[i] <= arg_d[i];
        end
    end

    assign ap_start = ap_start_q;
    assign irq      = irq_q;

    for (genvar g = 0; g < NUM_ARGS; g++) begin : g_args
        assign args[g*DW +: DW] = arg_q[g];
    end

    // ---------------- read channel FSM ----------------
    r_state_e      r_state_q;
    logic          arready_q;
    logic          rvalid_q;
    logic [DW-1:0] rdata_q;

    assign ar_hs = (r_state_q == R_IDLE) & arready_q & axil.AXI_LITE_arvalid;

    // Unmapped words read as zero.
    always_comb begin
        rd_mux = '0;
        if (rd_idx == IDX_CTRL)     rd_mux[3:0] = {ap_ready, ap_idle, done_q, ap_start_q};
        else if (rd_idx == IDX_GIE) rd_mux[0]   = gie_q;
        else if (rd_idx == IDX_IER) rd_mux[0]   = ier_q;
        else if (rd_idx == IDX_ISR) rd_mux[0]   = isr_q;
        else begin
            for (int i = 0; i < NUM_ARGS; i++) begin
                if (rd_idx == IDX_ARG0 + IW'(i)) rd_mux = arg_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rd_mux;
                        r_state_q <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (axil.AXI_LITE_rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign axil.AXI_LITE_arready = arready_q;
    assign axil.AXI_LITE_rvalid  = rvalid_q;
    assign axil.AXI_LITE_rdata   = rdata_q;
    assign axil.AXI_LITE_rresp   = 2'b00;

    // Protection bits and byte offset carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{axil.AXI_LITE_awprot, axil.AXI_LITE_arprot,
                           axil.AXI_LITE_awaddr[1:0], axil.AXI_LITE_araddr[1:0]};

endmodule
